// File: rtl/ps2_xt_translator.sv
// rtl/ps2_xt_translator.sv - PS/2 set-2 keyboard to IBM PC XT set-1 keyboard port bridge
//
// Ports:
//   CLK, RESET_N            system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA       keyboard-side clock/data (asynchronous, synchronised here)
//   KBD_RESET_N             PC keyboard-reset request (active low, synchronous)
//   KBD_INHIBIT             PC not ready; holds off the next XT frame
//   KBD_CLK, KBD_DATA       XT clock/data toward the PC
//   PARITY_ERR              one-cycle pulse per dropped PS/2 frame
//   OVERFLOW                sticky; a translated byte was lost to a full FIFO
//   FIFO_COUNT              translated-byte buffer occupancy
module ps2_xt_translator #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4,
  parameter int RX_TIMEOUT = 2000,
  parameter int XT_HALF    = 250,
  parameter int XT_GAP     = 500
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  input  logic                        KBD_RESET_N,
  input  logic                        KBD_INHIBIT,
  output logic                        KBD_CLK,
  output logic                        KBD_DATA,
  output logic                        PARITY_ERR,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int RW   = $clog2(RX_TIMEOUT + 1);
  localparam int TMAX = (XT_HALF > XT_GAP) ? XT_HALF : XT_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  // Set 2 -> set 1 translation for codes 00..7F (8042 controller table).
  localparam logic [7:0] XLAT [0:127] = '{
    8'hff,8'h43,8'h41,8'h3f,8'h3d,8'h3b,8'h3c,8'h58,8'h64,8'h44,8'h42,8'h40,8'h3e,8'h0f,8'h29,8'h59,
    8'h65,8'h38,8'h2a,8'h70,8'h1d,8'h10,8'h02,8'h5a,8'h66,8'h71,8'h2c,8'h1f,8'h1e,8'h11,8'h03,8'h5b,
    8'h67,8'h2e,8'h2d,8'h20,8'h12,8'h05,8'h04,8'h5c,8'h68,8'h39,8'h2f,8'h21,8'h14,8'h13,8'h06,8'h5d,
    8'h69,8'h31,8'h30,8'h23,8'h22,8'h15,8'h07,8'h5e,8'h6a,8'h72,8'h32,8'h24,8'h16,8'h08,8'h09,8'h5f,
    8'h6b,8'h33,8'h25,8'h17,8'h18,8'h0b,8'h0a,8'h60,8'h6c,8'h34,8'h35,8'h26,8'h27,8'h19,8'h0c,8'h61,
    8'h6d,8'h73,8'h28,8'h74,8'h1a,8'h0d,8'h62,8'h6e,8'h3a,8'h36,8'h1c,8'h1b,8'h75,8'h2b,8'h63,8'h76,
    8'h55,8'h56,8'h77,8'h78,8'h79,8'h7a,8'h0e,8'h7b,8'h7c,8'h4f,8'h7d,8'h4b,8'h47,8'h7e,8'h7f,8'h6f,
    8'h52,8'h53,8'h50,8'h4c,8'h4d,8'h48,8'h01,8'h45,8'h57,8'h4e,8'h51,8'h4a,8'h37,8'h49,8'h46,8'h54
  };

  // ---------------- input synchronisers and clock glitch filter ----------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2, clk_flt;
  logic [FW-1:0] flt_cnt;
  logic          flt_hit, fall;

  assign flt_hit = (clk_s2 != clk_flt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall    = flt_hit && clk_flt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_hit) begin
        clk_flt <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // ---------------- PS/2 receiver and break-prefix state ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t     rx_state;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_par, rx_valid, brk;
  logic [2:0]    rx_bits;
  logic [RW-1:0] rx_idle_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state    <= RX_IDLE;
      rx_shift    <= '0;
      rx_byte     <= '0;
      rx_par      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_bits     <= '0;
      rx_idle_cnt <= '0;
      brk         <= 1'b0;
      PARITY_ERR  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      PARITY_ERR <= 1'b0;
      // Translator side effect on the prefix flag, one cycle after the frame.
      if (rx_valid) begin
        if (rx_byte == 8'hF0) brk <= 1'b1;
        else if (rx_byte != 8'hE0 && rx_byte != 8'hE1) brk <= 1'b0;
      end
      if (!KBD_RESET_N) begin
        rx_state    <= RX_IDLE;
        rx_idle_cnt <= '0;
        brk         <= 1'b0;
      end else if (fall) begin
        rx_idle_cnt <= '0;
        case (rx_state)
          RX_IDLE: if (!dat_s2) begin
            rx_state <= RX_DATA;
            rx_bits  <= '0;
          end
          RX_DATA: begin
            rx_shift <= {dat_s2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 3'd7) rx_state <= RX_PAR;
          end
          RX_PAR: begin
            rx_par   <= dat_s2;
            rx_state <= RX_STOP;
          end
          RX_STOP: begin
            rx_state <= RX_IDLE;
            if (dat_s2 && (^{rx_shift, rx_par})) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end else begin
              PARITY_ERR <= 1'b1;
              brk        <= 1'b0;
            end
          end
        endcase
      end else if (rx_state != RX_IDLE) begin
        // A stalled keyboard clock abandons the partial frame silently.
        if (rx_idle_cnt == RW'(RX_TIMEOUT - 1)) begin
          rx_state    <= RX_IDLE;
          rx_idle_cnt <= '0;
        end else begin
          rx_idle_cnt <= rx_idle_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- translator / FIFO write side ----------------
  logic       kbd_rst_q, host_rel, push, wr_en, pop, full;
  logic [7:0] xlat_code, push_data;

  always_comb begin
    xlat_code = XLAT[rx_byte[6:0]];
    if (rx_byte[7]) begin
      if (rx_byte == 8'h83)      xlat_code = 8'h41;
      else if (rx_byte == 8'h84) xlat_code = 8'h54;
      else                       xlat_code = rx_byte;
    end
  end

  // The released host reset injects the self-test-passed byte AA.
  assign host_rel  = KBD_RESET_N && !kbd_rst_q;
  assign push      = host_rel || (KBD_RESET_N && rx_valid && rx_byte != 8'hF0);
  assign push_data = host_rel ? 8'hAA :
                     (rx_byte == 8'hE0 || rx_byte == 8'hE1) ? rx_byte :
                     (xlat_code | {brk, 7'b0});

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  typedef enum logic [1:0] {TX_IDLE, TX_BIT, TX_GAP} tx_state_t;
  tx_state_t tx_state;

  assign full  = (FIFO_COUNT == (AW + 1)'(FIFO_DEPTH));
  assign wr_en = push && !full;
  assign pop   = KBD_RESET_N && (tx_state == TX_IDLE) && (FIFO_COUNT != '0) && !KBD_INHIBIT;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
      OVERFLOW   <= 1'b0;
      kbd_rst_q  <= 1'b1;
    end else begin
      kbd_rst_q <= KBD_RESET_N;
      if (!KBD_RESET_N) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        FIFO_COUNT <= '0;
      end else begin
        if (push && full) OVERFLOW <= 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        FIFO_COUNT <= FIFO_COUNT + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      end
    end
  end

  // ---------------- XT transmitter ----------------
  logic [7:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic          tx_low;
  logic [TW-1:0] tx_tmr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_low   <= 1'b0;
      tx_tmr   <= '0;
      KBD_CLK  <= 1'b1;
      KBD_DATA <= 1'b1;
    end else if (!KBD_RESET_N) begin
      tx_state <= TX_IDLE;
      KBD_CLK  <= 1'b1;
      KBD_DATA <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (pop) begin
          tx_shift <= mem[rd_ptr];
          KBD_DATA <= 1'b1;           // start bit
          KBD_CLK  <= 1'b1;
          tx_bit   <= '0;
          tx_low   <= 1'b0;
          tx_tmr   <= '0;
          tx_state <= TX_BIT;
        end
        TX_BIT: begin
          if (tx_tmr == TW'(XT_HALF - 1)) begin
            tx_tmr <= '0;
            if (!tx_low) begin
              tx_low  <= 1'b1;
              KBD_CLK <= 1'b0;
            end else begin
              tx_low  <= 1'b0;
              KBD_CLK <= 1'b1;
              if (tx_bit == 4'd8) begin
                KBD_DATA <= 1'b1;
                tx_state <= TX_GAP;
              end else begin
                // Next bit goes out together with the rising edge the PC samples on.
                KBD_DATA <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 1'b1;
              end
            end
          end else begin
            tx_tmr <= tx_tmr + 1'b1;
          end
        end
        TX_GAP: begin
          if (tx_tmr == TW'(XT_GAP - 1)) tx_state <= TX_IDLE;
          else tx_tmr <= tx_tmr + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_xt_translator.sv
// tb/tb_ps2_xt_translator.sv - scoreboard testbench for ps2_xt_translator
module tb_ps2_xt_translator;
  localparam int FD = 4;
  localparam int FL = 4;
  localparam int RT = 300;
  localparam int XH = 10;
  localparam int XG = 20;
  localparam int PH = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kbd_reset_n = 1'b1;
  logic       kbd_inhibit = 1'b0;
  logic       kbd_clk, kbd_data, parity_err, overflow;
  logic [2:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  int         perr_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_xt_translator #(
    .FIFO_DEPTH(FD), .FILTER_LEN(FL), .RX_TIMEOUT(RT), .XT_HALF(XH), .XT_GAP(XG)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KBD_RESET_N(kbd_reset_n), .KBD_INHIBIT(kbd_inhibit),
    .KBD_CLK(kbd_clk), .KBD_DATA(kbd_data), .PARITY_ERR(parity_err),
    .OVERFLOW(overflow), .FIFO_COUNT(fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(PH);
      ps2_clk = 1'b0;
      cyc(PH);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(PH);
  endtask

  task automatic ps2_send(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    ps2_bits(f, 11);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      cyc(1);
      t++;
    end
    cyc(300);
    check(name, exp_q.size(), 0);
  endtask

  // XT monitor: a bit is the data level held while KBD_CLK was low, taken at its rise.
  initial begin
    int         nb;
    logic [8:0] sh;
    logic       pk, pd;
    logic [7:0] e;
    nb = 0; sh = '0; pk = 1'b1; pd = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n || !kbd_reset_n) begin
        nb = 0;
      end else if (kbd_clk && !pk) begin
        sh = {pd, sh[8:1]};
        nb++;
        if (nb == 9) begin
          nb = 0;
          check("xt_start_bit", {31'd0, sh[0]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xt_unexpected_frame act=%0h exp=none", sh[8:1]);
          end else begin
            e = exp_q.pop_front();
            check("xt_byte", {24'd0, sh[8:1]}, {24'd0, e});
          end
        end
      end
      pk = kbd_clk;
      pd = kbd_data;
      if (parity_err) perr_cnt++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] tcode [5];
    logic [7:0] tres  [5];
    logic [7:0] qcode [5];
    logic [7:0] qres  [5];
    int         t;
    tcode = '{8'h83, 8'h00, 8'h76, 8'h90, 8'h05};
    tres  = '{8'h41, 8'hFF, 8'h01, 8'h90, 8'h3B};
    qcode = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    qres  = '{8'h1E, 8'h30, 8'h2E, 8'h20, 8'h12};

    cyc(3);
    check("rst_kbd_clk", {31'd0, kbd_clk}, 32'd1);
    check("rst_kbd_data", {31'd0, kbd_data}, 32'd1);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // 1: single make code, held in the FIFO while inhibited
    kbd_inhibit = 1'b1;
    exp_q.push_back(8'h1E);
    ps2_send(8'h1C, 1'b0);
    cyc(5);
    check("t1_count_one", {29'd0, fifo_count}, 32'd1);
    kbd_inhibit = 1'b0;
    drain("t1_drain");
    check("t1_count_zero", {29'd0, fifo_count}, 32'd0);

    // 2: break prefix folding and extended prefix
    exp_q.push_back(8'h9E);
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h1C, 1'b0);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hC8);
    ps2_send(8'hE0, 1'b0);
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h75, 1'b0);
    drain("t2_drain");

    // table corners: high codes, 00, 83
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tres[i]);
      ps2_send(tcode[i], 1'b0);
    end
    drain("tbl_drain");

    // 3: parity error drops the frame and clears a pending break
    ps2_send(8'hF0, 1'b0);
    ps2_send(8'h1C, 1'b1);
    cyc(2);
    check("t3_perr_pulse", perr_cnt, 1);
    exp_q.push_back(8'h1E);
    ps2_send(8'h1C, 1'b0);
    drain("t3_drain");

    // 4: overflow with inhibited PC
    check("t4_no_overflow_yet", {31'd0, overflow}, 32'd0);
    kbd_inhibit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(qres[i]);
      ps2_send(qcode[i], 1'b0);
    end
    cyc(5);
    check("t4_count_full", {29'd0, fifo_count}, 32'd4);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    kbd_inhibit = 1'b0;
    drain("t4_drain");

    // 5: stalled partial frame is discarded without an error
    ps2_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    cyc(RT + 100);
    exp_q.push_back(8'h1E);
    ps2_send(8'h1C, 1'b0);
    drain("t5_drain");
    check("t5_no_perr", perr_cnt, 1);

    // 6: host reset in the middle of a transmission
    kbd_inhibit = 1'b1;
    for (int i = 0; i < 3; i++) ps2_send(qcode[i], 1'b0);
    cyc(5);
    check("t6_count_three", {29'd0, fifo_count}, 32'd3);
    kbd_inhibit = 1'b0;
    t = 0;
    while (kbd_clk && t < 200) begin
      cyc(1);
      t++;
    end
    check("t6_tx_started", {31'd0, kbd_clk}, 32'd0);
    cyc(3);
    kbd_reset_n = 1'b0;
    cyc(3);
    check("t6_kbd_clk", {31'd0, kbd_clk}, 32'd1);
    check("t6_kbd_data", {31'd0, kbd_data}, 32'd1);
    check("t6_count_flushed", {29'd0, fifo_count}, 32'd0);
    check("t6_overflow_kept", {31'd0, overflow}, 32'd1);
    exp_q.push_back(8'hAA);
    kbd_reset_n = 1'b1;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
